uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin controller that shares one UART transmitter (byte input, one-cycle valid pulse, `rfd` ready indication) among `NUM_REQ` byte-stream requesters. Each grant is a burst: an optional ID header byte followed by up to `MAX_BURST` data bytes from the winning requester. The block sits between client logic and the UART top level's `din`/`din_vld`/`rfd` port, so a receiver can demultiplex the streams by header.

## Interface
- `NUM_REQ`, 4 — number of requesters, 2..16.
- `DI_WIDTH`, 8 — byte width; must be 8 when `ID_HDR`=1.
- `MAX_BURST`, 16 — maximum data bytes per grant, ≥1.
- `ID_HDR`, 1 — 1: send header byte `{4'hA, id[3:0]}` at the start of each grant; 0: no header.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset; asynchronous, active-low.
- `req_data` in `NUM_REQ*DI_WIDTH` — requester i byte at `[i*DI_WIDTH +: DI_WIDTH]`.
- `req_vld` in `NUM_REQ` — requester i has a byte.
- `req_last` in `NUM_REQ` — the current byte ends requester i's packet.
- `req_rdy` out `NUM_REQ` — byte accepted when `req_vld[i] & req_rdy[i]`.
- `uart_din` out `DI_WIDTH` — byte to the UART transmitter.
- `uart_din_vld` out 1 — one-cycle load pulse to the UART.
- `uart_rfd` in 1 — UART idle and ready for a byte.
- `grant` out `NUM_REQ` — one-hot current owner; all zero when none.
- `busy` out 1 — high whenever `grant` ≠ 0.

## Operation
- Reset values: `uart_din`=0, `uart_din_vld`=0, `grant`=0, `req_rdy`=0, `busy`=0. Internally: round-robin pointer 0, byte count 0, state ARB.
- ARB:
  - If no `req_vld` bit is set, stay in ARB.
  - Otherwise pick the first requester with `req_vld` set, searching from the pointer upward with wrap-around.
  - Register the winner into `grant`, clear the count, and go to HDR (`ID_HDR`=1) or SEND.
- HDR:
  - When `uart_rfd`=1, register `uart_din`=header and pulse `uart_din_vld`.
  - Go to WAIT with return target SEND.
- SEND:
  - Requester g is the granted one. `req_rdy[g]` = (state==SEND) & `uart_rfd` & `req_vld[g]`; combinational. All other `req_rdy` bits are 0.
  - On a transfer: register the byte into `uart_din`, pulse `uart_din_vld`, increment the count, capture `req_last[g]`, and go to WAIT.
  - If `req_vld[g]`=0 while in SEND (regardless of `uart_rfd`), release the grant and go to ARB. A header already sent with no data bytes after it is legal.
- WAIT:
  - Hold until `uart_rfd`=0, meaning the UART has taken the byte.
  - Then go to ARB if the burst has ended; otherwise return to the target state (SEND).
  - The burst has ended when the captured last flag is set or the count equals `MAX_BURST`.
- Release, on either path above:
  - `grant` goes to 0 on entry to ARB.
  - The pointer becomes (g+1) mod `NUM_REQ`, so the released requester has lowest priority next round.
- The count is `$clog2(MAX_BURST+1)` bits and saturates at `MAX_BURST`; it never wraps.
- `req_vld` bits of non-granted requesters are ignored during a burst.
- `uart_din` holds its last value between pulses.

## Timing
- `req_vld` rises in ARB at cycle 0 → `grant` valid at cycle 1.
  - Header pulse no earlier than cycle 2.
  - First data `req_rdy` no earlier than cycle 1 when `ID_HDR`=0.
- `uart_din_vld` is high for exactly one cycle per byte, aligned with the registered `uart_din`.
- No second pulse is issued until `uart_rfd` has been seen low and then high again.
- The arbitration gap between bursts is 1 cycle (ARB) plus the time for `uart_rfd` to return high.
- Reset asserted mid-burst: all outputs return to reset values immediately, and the partially sent burst is abandoned.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (ARB, HDR, SEND, WAIT);
  - the header tag constant `4'hA`;
  - a function that builds the header byte.
- Sub-module `rr_arbiter`: a combinational round-robin pick. Inputs: request vector and pointer. Outputs: one-hot winner and winner index. It is reused by any future RX-side scheduler.

## Test plan
- `ID_HDR`=1; requester 2 sends bytes 0x11, 0x22 with `last` on 0x22; UART model drops `rfd` 1 cycle after each pulse and raises it 20 cycles later. Expected UART bytes: 0xA2, 0x11, 0x22; then `grant`=0 and pointer=3.
- All 4 requesters continuously valid with `last` on every byte, `ID_HDR`=0. Expected grant order: 0, 1, 2, 3, 0, with one byte each.
- Requester 1 streams 20 bytes with no `last`, `MAX_BURST`=16, requester 3 also valid. Expected: after 16 bytes, `grant` moves to 3; requester 1 resumes later.
- Requester 0 drops `req_vld` after 3 bytes. Expected: release, `grant`=0 within 1 cycle, pointer=1.
- `uart_rfd` held low for 100 cycles after a pulse. Expected: no further `uart_din_vld` and no `req_rdy` until `rfd` rises.
- `rst` asserted during WAIT. Expected: all outputs 0 asynchronously; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbitration logic.
// Holds the burst FSM state type and the header byte builder.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_HDR  = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } tx_state_t;

  localparam logic [3:0] HDR_TAG = 4'hA;

  // Header byte that lets a receiver demultiplex streams by requester id.
  function automatic logic [7:0] make_hdr(input logic [3:0] id);
    return {HDR_TAG, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping around. Shared with any future receive-side scheduler.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found     = 1'b1;
        gnt[w_cand] = 1'b1;
        idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte streams using round-robin
// bursts, each optionally prefixed by an id header byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DI_WIDTH  = 8,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned ID_HDR    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ*DI_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]           req_vld,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_rdy,
  output logic [DI_WIDTH-1:0]          uart_din,
  output logic                         uart_din_vld,
  input  logic                         uart_rfd,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  tx_state_t             r_state;
  tx_state_t             r_ret;
  logic [NUM_REQ-1:0]    r_grant;
  logic [IDX_W-1:0]      r_gidx;
  logic [IDX_W-1:0]      r_ptr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_last;
  logic [DI_WIDTH-1:0]   r_din;
  logic                  r_din_vld;

  logic [NUM_REQ-1:0]    w_win;
  logic [IDX_W-1:0]      w_win_idx;
  logic                  w_g_vld;
  logic                  w_g_last;
  logic [DI_WIDTH-1:0]   w_g_data;
  logic                  w_xfer;
  logic                  w_burst_end;
  logic                  w_release;
  logic [IDX_W-1:0]      w_ptr_next;
  logic [DI_WIDTH-1:0]   w_hdr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req (req_vld),
    .ptr (r_ptr),
    .gnt (w_win),
    .idx (w_win_idx)
  );

  assign w_g_vld     = req_vld[r_gidx];
  assign w_g_last    = req_last[r_gidx];
  assign w_g_data    = req_data[32'(r_gidx) * DI_WIDTH +: DI_WIDTH];
  assign w_xfer      = (r_state == ST_SEND) & uart_rfd & w_g_vld;
  assign w_burst_end = r_last | (r_cnt == CNT_W'(MAX_BURST));
  assign w_ptr_next  = (r_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
  assign w_hdr       = DI_WIDTH'(make_hdr(4'(r_gidx)));

  // Both release paths share one update so grant and pointer stay in step.
  assign w_release = ((r_state == ST_SEND) & ~w_g_vld) |
                     ((r_state == ST_WAIT) & ~uart_rfd & w_burst_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_ARB;
      r_ret     <= ST_SEND;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_last    <= 1'b0;
      r_din     <= '0;
      r_din_vld <= 1'b0;
    end else begin
      r_din_vld <= 1'b0;
      if (w_release) begin
        r_grant <= '0;
        r_ptr   <= w_ptr_next;
        r_state <= ST_ARB;
      end else begin
        case (r_state)
          ST_ARB: begin
            if (|req_vld) begin
              r_grant <= w_win;
              r_gidx  <= w_win_idx;
              r_cnt   <= '0;
              r_last  <= 1'b0;
              r_state <= (ID_HDR != 0) ? ST_HDR : ST_SEND;
            end
          end
          ST_HDR: begin
            if (uart_rfd) begin
              r_din     <= w_hdr;
              r_din_vld <= 1'b1;
              r_ret     <= ST_SEND;
              r_state   <= ST_WAIT;
            end
          end
          ST_SEND: begin
            if (w_xfer) begin
              r_din     <= w_g_data;
              r_din_vld <= 1'b1;
              r_last    <= w_g_last;
              if (r_cnt != CNT_W'(MAX_BURST)) r_cnt <= r_cnt + 1'b1;
              r_state   <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (!uart_rfd) r_state <= r_ret;
          end
          default: r_state <= ST_ARB;
        endcase
      end
    end
  end

  assign req_rdy      = w_xfer ? r_grant : '0;
  assign uart_din     = r_din;
  assign uart_din_vld = r_din_vld;
  assign grant        = r_grant;
  assign busy         = |r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: instance 0 sends headers, instance 1 does not; both share a
// simple UART rfd model and per-requester byte sources.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [N*W-1:0] data [2];
  logic [N-1:0]   vld  [2];
  logic [N-1:0]   last [2];
  logic [N-1:0]   rdy  [2];
  logic [N-1:0]   grant[2];
  logic [W-1:0]   din  [2];
  logic           dvld [2];
  logic           rfd  [2];
  logic           busy [2];

  uart_tx_arbiter #(.NUM_REQ(N), .DI_WIDTH(W), .MAX_BURST(16), .ID_HDR(1)) dut_a (
    .clk(clk), .rst(rst), .req_data(data[0]), .req_vld(vld[0]), .req_last(last[0]),
    .req_rdy(rdy[0]), .uart_din(din[0]), .uart_din_vld(dvld[0]), .uart_rfd(rfd[0]),
    .grant(grant[0]), .busy(busy[0]));

  uart_tx_arbiter #(.NUM_REQ(N), .DI_WIDTH(W), .MAX_BURST(16), .ID_HDR(0)) dut_b (
    .clk(clk), .rst(rst), .req_data(data[1]), .req_vld(vld[1]), .req_last(last[1]),
    .req_rdy(rdy[1]), .uart_din(din[1]), .uart_din_vld(dvld[1]), .uart_rfd(rfd[1]),
    .grant(grant[1]), .busy(busy[1]));

  int          rem  [2][N];
  logic [7:0]  nxt  [2][N];
  logic [7:0]  stp  [2][N];
  bit          lend [2][N];
  bit          leach[2][N];
  bit          acc  [2][N];
  int          hold [2];
  int          rcnt [2];
  bit          flow [2];

  logic [7:0]  lb_a[$];
  logic [7:0]  lb_b[$];
  int          lg_a[$];
  int          lg_b[$];

  int checks = 0;
  int errors = 0;

  function automatic int oh_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  // UART rfd model, byte logger and requester sources; inputs change on negedge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        rfd[d]  = 1'b1;
        rcnt[d] = 0;
      end else if (dvld[d]) begin
        rfd[d]  = 1'b0;
        rcnt[d] = hold[d];
        if (d == 0) begin lb_a.push_back(din[d]); lg_a.push_back(oh_idx(grant[d])); end
        else        begin lb_b.push_back(din[d]); lg_b.push_back(oh_idx(grant[d])); end
      end else if (!rfd[d] && !flow[d]) begin
        if (rcnt[d] == 0) rfd[d] = 1'b1;
        else              rcnt[d] = rcnt[d] - 1;
      end
      for (int i = 0; i < N; i++) begin
        if (acc[d][i] && rem[d][i] > 0) begin
          rem[d][i] = rem[d][i] - 1;
          nxt[d][i] = nxt[d][i] + stp[d][i];
        end
        vld[d][i]          = (rem[d][i] > 0);
        data[d][i*W +: W]  = nxt[d][i];
        last[d][i]         = leach[d][i] || (lend[d][i] && rem[d][i] == 1);
      end
    end
    #1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) acc[d][i] = vld[d][i] & rdy[d][i];
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic src(input int d, input int i, input int rm, input logic [7:0] nx,
                     input logic [7:0] st, input bit le, input bit lh);
    rem[d][i] = rm; nxt[d][i] = nx; stp[d][i] = st; lend[d][i] = le; leach[d][i] = lh;
  endtask

  task automatic wait_log(input int d, input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (((d == 0) ? lb_a.size() : lb_b.size()) >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int d, input int bound, output bit ok);
    int s;
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      tick();
      s = 0;
      for (int i = 0; i < N; i++) s += rem[d][i];
      if (s == 0 && !busy[d]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      checks++; if (grant[d] !== 4'b0000) begin errors++; $display("FAIL reset_grant%0d: got %b expected 0000", d, grant[d]); end
      checks++; if (rdy[d] !== 4'b0000) begin errors++; $display("FAIL reset_rdy%0d: got %b expected 0000", d, rdy[d]); end
      checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy%0d: got %b expected 0", d, busy[d]); end
      checks++; if (dvld[d] !== 1'b0) begin errors++; $display("FAIL reset_dvld%0d: got %b expected 0", d, dvld[d]); end
      checks++; if (din[d] !== 8'h00) begin errors++; $display("FAIL reset_din%0d: got %h expected 00", d, din[d]); end
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_header_burst();
    bit ok;
    logic [7:0] exp_b[3];
    logic [7:0] exp_c[4];
    exp_b = '{8'hA2, 8'h11, 8'h22};
    exp_c = '{8'hA3, 8'hC0, 8'hA0, 8'hB0};
    hold[0] = 20;
    lb_a.delete(); lg_a.delete();
    src(0, 2, 2, 8'h11, 8'h11, 1'b1, 1'b0);
    tick();
    checks++; if (grant[0] !== 4'b0100) begin errors++; $display("FAIL hdr_grant_c1: got %b expected 0100", grant[0]); end
    checks++; if (dvld[0] !== 1'b0) begin errors++; $display("FAIL hdr_early_pulse: got %b expected 0", dvld[0]); end
    checks++; if (rdy[0] !== 4'b0000) begin errors++; $display("FAIL hdr_rdy_c1: got %b expected 0000", rdy[0]); end
    tick();
    checks++; if (dvld[0] !== 1'b1 || din[0] !== 8'hA2) begin errors++; $display("FAIL hdr_pulse_c2: got vld %b din %h expected vld 1 din a2", dvld[0], din[0]); end
    wait_log(0, 3, 300, ok);
    if (ok) wait_idle(0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hdr_wait: got timeout expected 3 bytes then idle"); end
    if (ok) begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (lb_a[k] !== exp_b[k] || lg_a[k] != 2) begin errors++; $display("FAIL hdr_byte%0d: got %h from %0d expected %h from 2", k, lb_a[k], lg_a[k], exp_b[k]); end
      end
      checks++; if (grant[0] !== 4'b0000) begin errors++; $display("FAIL hdr_release: got %b expected 0000", grant[0]); end
    end
    // Pointer now 3: requester 3 must beat requester 0.
    hold[0] = 2;
    lb_a.delete(); lg_a.delete();
    src(0, 0, 1, 8'hB0, 8'h01, 1'b1, 1'b0);
    src(0, 3, 1, 8'hC0, 8'h01, 1'b1, 1'b0);
    tick();
    checks++; if (grant[0] !== 4'b1000) begin errors++; $display("FAIL ptr3_grant: got %b expected 1000", grant[0]); end
    wait_log(0, 4, 300, ok);
    if (ok) wait_idle(0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ptr3_wait: got timeout expected 4 bytes then idle"); end
    if (ok) for (int k = 0; k < 4; k++) begin
      checks++; if (lb_a[k] !== exp_c[k]) begin errors++; $display("FAIL ptr3_byte%0d: got %h expected %h", k, lb_a[k], exp_c[k]); end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_g[5];
    logic [7:0] exp_d[5];
    exp_g = '{0, 1, 2, 3, 0};
    exp_d = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01};
    lb_b.delete(); lg_b.delete();
    for (int i = 0; i < N; i++) src(1, i, 5, 8'(i * 16), 8'h01, 1'b0, 1'b1);
    tick();
    checks++; if (grant[1] !== 4'b0001 || rdy[1] !== 4'b0001) begin errors++; $display("FAIL rr_c1: got grant %b rdy %b expected 0001 0001", grant[1], rdy[1]); end
    wait_log(1, 5, 400, ok);
    for (int i = 0; i < N; i++) rem[1][i] = 0;
    if (ok) wait_idle(1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_wait: got timeout expected 5 bytes then idle"); end
    if (ok) for (int k = 0; k < 5; k++) begin
      checks++; if (lg_b[k] != exp_g[k] || lb_b[k] !== exp_d[k]) begin errors++; $display("FAIL rr_byte%0d: got %h from %0d expected %h from %0d", k, lb_b[k], lg_b[k], exp_d[k], exp_g[k]); end
    end
  endtask

  task automatic test_max_burst();
    bit ok;
    logic [7:0] exq[$];
    lb_a.delete(); lg_a.delete();
    exq.push_back(8'hA1);
    for (int k = 0; k < 16; k++) exq.push_back(8'(8'h40 + k));
    exq.push_back(8'hA3);
    exq.push_back(8'h90);
    exq.push_back(8'hA1);
    for (int k = 0; k < 4; k++) exq.push_back(8'(8'h50 + k));
    src(0, 1, 20, 8'h40, 8'h01, 1'b0, 1'b0);
    src(0, 3, 1, 8'h90, 8'h01, 1'b1, 1'b0);
    wait_log(0, 24, 1500, ok);
    if (ok) wait_idle(0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_wait: got timeout expected 24 bytes then idle"); end
    if (ok) begin
      checks++; if (lb_a.size() != 24) begin errors++; $display("FAIL burst_count: got %0d expected 24", lb_a.size()); end
      for (int k = 0; k < 24; k++) begin
        checks++; if (lb_a[k] !== exq[k]) begin errors++; $display("FAIL burst_byte%0d: got %h expected %h", k, lb_a[k], exq[k]); end
      end
    end
  endtask

  task automatic test_vld_drop();
    bit ok;
    lb_a.delete(); lg_a.delete();
    src(0, 0, 3, 8'h60, 8'h01, 1'b0, 1'b0);
    wait_log(0, 4, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_wait: got timeout expected 4 bytes"); end
    if (ok) begin
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL drop_early: got busy %b expected 1", busy[0]); end
      tick();
      checks++; if (grant[0] !== 4'b0000 || busy[0] !== 1'b0) begin errors++; $display("FAIL drop_release: got grant %b busy %b expected 0000 0", grant[0], busy[0]); end
      checks++; if (lb_a[3] !== 8'h62) begin errors++; $display("FAIL drop_last_byte: got %h expected 62", lb_a[3]); end
    end
    // Pointer now 1: requester 1 must beat requester 0.
    src(0, 0, 1, 8'hD0, 8'h01, 1'b1, 1'b0);
    src(0, 1, 1, 8'hD1, 8'h01, 1'b1, 1'b0);
    tick();
    checks++; if (grant[0] !== 4'b0010) begin errors++; $display("FAIL ptr1_grant: got %b expected 0010", grant[0]); end
    wait_log(0, 8, 300, ok);
    if (ok) wait_idle(0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ptr1_wait: got timeout expected 8 bytes then idle"); end
  endtask

  task automatic test_rfd_stall();
    bit ok;
    int bad;
    lb_a.delete(); lg_a.delete();
    src(0, 2, 2, 8'h70, 8'h01, 1'b1, 1'b0);
    wait_log(0, 1, 100, ok);
    flow[0] = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL stall_hdr: got timeout expected header"); end
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (dvld[0] !== 1'b0 || rdy[0] !== 4'b0000) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_quiet: got %0d active cycles expected 0", bad); end
    checks++; if (lb_a.size() != 1) begin errors++; $display("FAIL stall_count: got %0d expected 1", lb_a.size()); end
    flow[0] = 1'b0;
    wait_log(0, 3, 300, ok);
    if (ok) wait_idle(0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_resume: got timeout expected 3 bytes then idle"); end
    if (ok) begin
      checks++; if (lb_a[0] !== 8'hA2 || lb_a[1] !== 8'h70 || lb_a[2] !== 8'h71) begin errors++; $display("FAIL stall_bytes: got %h %h %h expected a2 70 71", lb_a[0], lb_a[1], lb_a[2]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    hold[0] = 20;
    lb_a.delete(); lg_a.delete();
    src(0, 3, 3, 8'h80, 8'h01, 1'b1, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (lb_a.size() >= 1 && dvld[0] === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_wait: got timeout expected data pulse"); end
    rst = 1'b0;
    #1;
    checks++; if (grant[0] !== 4'b0000 || busy[0] !== 1'b0 || rdy[0] !== 4'b0000) begin errors++; $display("FAIL rstmid_ctl: got grant %b busy %b rdy %b expected 0000 0 0000", grant[0], busy[0], rdy[0]); end
    checks++; if (dvld[0] !== 1'b0 || din[0] !== 8'h00) begin errors++; $display("FAIL rstmid_data: got vld %b din %h expected 0 00", dvld[0], din[0]); end
    for (int i = 0; i < N; i++) rem[0][i] = 0;
    hold[0] = 2;
    tick(); tick();
    rst = 1'b1;
    src(0, 0, 1, 8'hE0, 8'h01, 1'b1, 1'b0);
    src(0, 3, 1, 8'hE3, 8'h01, 1'b1, 1'b0);
    tick();
    checks++; if (grant[0] !== 4'b0001) begin errors++; $display("FAIL rstmid_restart: got %b expected 0001", grant[0]); end
    wait_idle(0, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_idle: got timeout expected idle"); end
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      hold[d] = 2; rcnt[d] = 0; flow[d] = 1'b0; rfd[d] = 1'b1;
      vld[d] = '0; last[d] = '0; data[d] = '0;
      for (int i = 0; i < N; i++) begin
        rem[d][i] = 0; nxt[d][i] = 8'h00; stp[d][i] = 8'h01;
        lend[d][i] = 1'b0; leach[d][i] = 1'b0; acc[d][i] = 1'b0;
      end
    end
    test_reset();
    test_header_burst();
    test_round_robin();
    test_max_burst();
    test_vld_drop();
    test_rfd_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
